// File: rtl/wb_writer_pkg.sv
// Shared definitions for the writeback path: data width, register-index
// width and the RV32I load funct3 encodings.
package wb_writer_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } ld_funct3_e;

endpackage

// File: rtl/wb_writer_load_ext.sv
// Load data extension (combinational).
//   funct3  : RV32I load type
//   addr_lo : byte offset of the load address
//   rdata   : raw aligned memory word
//   data    : extended load result
// Halfword select uses addr_lo[1] only; unknown funct3 codes pass the word.
module load_ext
  import wb_writer_pkg::*;
#(
  parameter int unsigned XLEN = wb_writer_pkg::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_writer.sv
// Writeback producer for the register file write port.
//   alu_valid/alu_rd/alu_data/alu_ready : ALU result handshake
//   ld_valid/ld_rd/ld_funct3/ld_addr_lo/ld_rdata/ld_ready : load return
//   RegWEn/regD/wb_data : registered register-file write port
//   pend_mask : destinations held by valid buffered ALU results
//   busy      : buffer non-empty or a write is on the output port
// Loads always win; ALU results losing arbitration go to an in-order FIFO.
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = wb_writer_pkg::XLEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  output logic             alu_ready,
  input  logic             ld_valid,
  input  logic [4:0]       ld_rd,
  input  logic [2:0]       ld_funct3,
  input  logic [1:0]       ld_addr_lo,
  input  logic [XLEN-1:0]  ld_rdata,
  output logic             ld_ready,
  output logic             RegWEn,
  output logic [4:0]       regD,
  output logic [XLEN-1:0]  wb_data,
  output logic [31:0]      pend_mask,
  output logic             busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [REG_W-1:0] q_rd   [DEPTH];
  logic [XLEN-1:0]  q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [DEPTH-1:0] q_vld_nxt;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [31:0]      pend_nxt;
  logic [XLEN-1:0]  ld_ext;

  logic full;
  logic empty;
  logic alu_fire;
  logic sel_ld;
  logic sel_head;
  logic sel_byp;
  logic push;
  logic pop;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3  (ld_funct3),
    .addr_lo (ld_addr_lo),
    .rdata   (ld_rdata),
    .data    (ld_ext)
  );

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign alu_ready = reset && !full;
  assign ld_ready  = reset;
  assign busy      = !empty || RegWEn;

  assign alu_fire = alu_valid && alu_ready;
  assign sel_ld   = ld_valid;
  assign sel_head = !ld_valid && !empty;
  assign sel_byp  = !ld_valid && empty && alu_fire;
  assign pop      = sel_head;
  assign push     = alu_fire && !sel_byp && (alu_rd != '0);

  // Squash and pop act on entries already in the FIFO; the push is applied
  // last so an entry written this cycle is never squashed by the load.
  always_comb begin
    q_vld_nxt = q_vld;
    if (sel_ld) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (q_rd[i[AW-1:0]] == ld_rd) begin
          q_vld_nxt[i[AW-1:0]] = 1'b0;
        end
      end
    end
    if (pop) begin
      q_vld_nxt[rd_ptr] = 1'b0;
    end

    pend_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (q_vld_nxt[i[AW-1:0]]) begin
        pend_nxt[q_rd[i[AW-1:0]]] = 1'b1;
      end
    end
    if (push) begin
      q_vld_nxt[wr_ptr] = 1'b1;
      pend_nxt[alu_rd]  = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset && push) begin
      q_rd[wr_ptr]   <= alu_rd;
      q_data[wr_ptr] <= alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_vld     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      pend_mask <= '0;
      RegWEn    <= 1'b0;
      regD      <= '0;
      wb_data   <= '0;
    end else begin
      q_vld     <= q_vld_nxt;
      pend_mask <= pend_nxt;

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      RegWEn <= 1'b0;
      if (sel_ld) begin
        RegWEn  <= (ld_rd != '0);
        regD    <= ld_rd;
        wb_data <= ld_ext;
      end else if (sel_head) begin
        // A squashed head still pops, but without a write.
        RegWEn  <= q_vld[rd_ptr];
        regD    <= q_rd[rd_ptr];
        wb_data <= q_data[rd_ptr];
      end else if (sel_byp) begin
        RegWEn  <= (alu_rd != '0);
        regD    <= alu_rd;
        wb_data <= alu_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_writer.sv
module tb_wb_writer;
  import wb_writer_pkg::*;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_rdata;
  logic        ld_ready;
  logic        RegWEn;
  logic [4:0]  regD;
  logic [31:0] wb_data;
  logic [31:0] pend_mask;
  logic        busy;

  int n_chk;
  int n_fail;

  wb_writer #(.DEPTH(2), .XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .ld_rdata   (ld_rdata),
    .ld_ready   (ld_ready),
    .RegWEn     (RegWEn),
    .regD       (regD),
    .wb_data    (wb_data),
    .pend_mask  (pend_mask),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lv;
    logic [4:0]  lrd;
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] ldat;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] dat;
    logic [31:0] pend;
    logic        ardy;
    logic        bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
    input logic [1:0] alo, input logic [31:0] ldat,
    input logic av, input logic [4:0] ard, input logic [31:0] adat,
    input logic wen, input logic [4:0] rd, input logic [31:0] dat,
    input logic [31:0] pend, input logic ardy, input logic bsy);
    vec_t v;
    v.lv = lv; v.lrd = lrd; v.f3 = f3; v.alo = alo; v.ldat = ldat;
    v.av = av; v.ard = ard; v.adat = adat;
    v.wen = wen; v.rd = rd; v.dat = dat; v.pend = pend;
    v.ardy = ardy; v.bsy = bsy;
    return v;
  endfunction

  function automatic logic [31:0] bit_of(input int r);
    return 32'd1 << r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lv, input logic [4:0] lrd, input logic [2:0] f3,
                       input logic [1:0] alo, input logic [31:0] ldat,
                       input logic av, input logic [4:0] ard, input logic [31:0] adat);
    ld_valid = lv; ld_rd = lrd; ld_funct3 = f3; ld_addr_lo = alo; ld_rdata = ldat;
    alu_valid = av; alu_rd = ard; alu_data = adat;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    drive(1'b0, 5'd0, 3'd0, 2'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    //    lv  lrd    f3       alo    ldat          av  ard    adat          wen rd     dat           pend                     ardy bsy
    // single bypass
    vecs.push_back(mk(0, 5'd0,  F3_LW,  2'd0, 32'h0,        1, 5'd5,  32'h11,       1, 5'd5,  32'h11,       32'h0,                   1, 1));
    // load wins, ALU buffered then drained
    vecs.push_back(mk(1, 5'd7,  F3_LW,  2'd0, 32'hDEADBEEF, 1, 5'd3,  32'h22,       1, 5'd7,  32'hDEADBEEF, bit_of(3),               1, 1));
    vecs.push_back(mk(0, 5'd0,  F3_LW,  2'd0, 32'h0,        0, 5'd0,  32'h0,        1, 5'd3,  32'h22,       32'h0,                   1, 1));
    // load extension
    vecs.push_back(mk(1, 5'd1,  F3_LB,  2'd3, 32'h80F07F81, 0, 5'd0,  32'h0,        1, 5'd1,  32'hFFFFFF80, 32'h0,                   1, 1));
    vecs.push_back(mk(1, 5'd2,  F3_LBU, 2'd0, 32'h80F07F81, 0, 5'd0,  32'h0,        1, 5'd2,  32'h00000081, 32'h0,                   1, 1));
    vecs.push_back(mk(1, 5'd4,  F3_LH,  2'd2, 32'h80F07F81, 0, 5'd0,  32'h0,        1, 5'd4,  32'hFFFF80F0, 32'h0,                   1, 1));
    vecs.push_back(mk(1, 5'd6,  F3_LHU, 2'd0, 32'h80F07F81, 0, 5'd0,  32'h0,        1, 5'd6,  32'h00007F81, 32'h0,                   1, 1));
    vecs.push_back(mk(1, 5'd8,  F3_LH,  2'd3, 32'h80F07F81, 0, 5'd0,  32'h0,        1, 5'd8,  32'hFFFF80F0, 32'h0,                   1, 1));
    vecs.push_back(mk(1, 5'd8,  3'b011, 2'd1, 32'h80F07F81, 0, 5'd0,  32'h0,        1, 5'd8,  32'h80F07F81, 32'h0,                   1, 1));
    // four back-to-back loads fill the FIFO, then in-order drain
    vecs.push_back(mk(1, 5'd20, F3_LW,  2'd0, 32'h1000,     1, 5'd10, 32'hA0,       1, 5'd20, 32'h1000,     bit_of(10),              1, 1));
    vecs.push_back(mk(1, 5'd21, F3_LW,  2'd0, 32'h1001,     1, 5'd11, 32'hB0,       1, 5'd21, 32'h1001,     bit_of(10) | bit_of(11), 0, 1));
    vecs.push_back(mk(1, 5'd22, F3_LW,  2'd0, 32'h1002,     1, 5'd12, 32'hC0,       1, 5'd22, 32'h1002,     bit_of(10) | bit_of(11), 0, 1));
    vecs.push_back(mk(1, 5'd23, F3_LW,  2'd0, 32'h1003,     1, 5'd12, 32'hC0,       1, 5'd23, 32'h1003,     bit_of(10) | bit_of(11), 0, 1));
    vecs.push_back(mk(0, 5'd0,  F3_LW,  2'd0, 32'h0,        1, 5'd12, 32'hC0,       1, 5'd10, 32'hA0,       bit_of(11),              1, 1));
    vecs.push_back(mk(0, 5'd0,  F3_LW,  2'd0, 32'h0,        1, 5'd12, 32'hC0,       1, 5'd11, 32'hB0,       bit_of(12),              1, 1));
    vecs.push_back(mk(0, 5'd0,  F3_LW,  2'd0, 32'h0,        0, 5'd0,  32'h0,        1, 5'd12, 32'hC0,       32'h0,                   1, 1));
    // squash of a buffered entry by a younger load
    vecs.push_back(mk(1, 5'd13, F3_LW,  2'd0, 32'h5,        1, 5'd9,  32'h1,        1, 5'd13, 32'h5,        bit_of(9),               1, 1));
    vecs.push_back(mk(1, 5'd9,  F3_LW,  2'd0, 32'h99,       0, 5'd0,  32'h0,        1, 5'd9,  32'h99,       32'h0,                   1, 1));
    vecs.push_back(mk(0, 5'd0,  F3_LW,  2'd0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        32'h0,                   1, 0));
    // same-cycle push is not squashed
    vecs.push_back(mk(1, 5'd14, F3_LW,  2'd0, 32'h7,        1, 5'd14, 32'h77,       1, 5'd14, 32'h7,        bit_of(14),              1, 1));
    vecs.push_back(mk(0, 5'd0,  F3_LW,  2'd0, 32'h0,        0, 5'd0,  32'h0,        1, 5'd14, 32'h77,       32'h0,                   1, 1));
    // rd==0 ALU results: never written, never buffered
    vecs.push_back(mk(0, 5'd0,  F3_LW,  2'd0, 32'h0,        1, 5'd0,  32'h55,       0, 5'd0,  32'h0,        32'h0,                   1, 0));
    vecs.push_back(mk(1, 5'd15, F3_LW,  2'd0, 32'h3,        1, 5'd0,  32'h9,        1, 5'd15, 32'h3,        32'h0,                   1, 1));
    vecs.push_back(mk(0, 5'd0,  F3_LW,  2'd0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        32'h0,                   1, 0));

    // reset state
    repeat (3) step();
    chk("rst.wen",   {31'd0, RegWEn},    32'd0);
    chk("rst.regd",  {27'd0, regD},      32'd0);
    chk("rst.data",  wb_data,            32'd0);
    chk("rst.pend",  pend_mask,          32'd0);
    chk("rst.busy",  {31'd0, busy},      32'd0);
    chk("rst.ardy",  {31'd0, alu_ready}, 32'd0);
    chk("rst.lrdy",  {31'd0, ld_ready},  32'd0);

    reset = 1'b1;
    #1;
    chk("rel.ardy", {31'd0, alu_ready}, 32'd1);
    chk("rel.lrdy", {31'd0, ld_ready},  32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].lv, vecs[i].lrd, vecs[i].f3, vecs[i].alo, vecs[i].ldat,
            vecs[i].av, vecs[i].ard, vecs[i].adat);
      step();
      chk($sformatf("v%0d.wen", i), {31'd0, RegWEn}, {31'd0, vecs[i].wen});
      if (vecs[i].wen) begin
        chk($sformatf("v%0d.regd", i), {27'd0, regD}, {27'd0, vecs[i].rd});
        chk($sformatf("v%0d.data", i), wb_data, vecs[i].dat);
      end
      chk($sformatf("v%0d.pend", i), pend_mask, vecs[i].pend);
      chk($sformatf("v%0d.ardy", i), {31'd0, alu_ready}, {31'd0, vecs[i].ardy});
      chk($sformatf("v%0d.busy", i), {31'd0, busy}, {31'd0, vecs[i].bsy});
    end

    // reset with two buffered entries discards them
    drive(1'b1, 5'd16, F3_LW, 2'd0, 32'h16, 1'b1, 5'd17, 32'h17);
    step();
    chk("mr.pend1", pend_mask, bit_of(17));
    drive(1'b1, 5'd18, F3_LW, 2'd0, 32'h18, 1'b1, 5'd19, 32'h19);
    step();
    chk("mr.pend2", pend_mask, bit_of(17) | bit_of(19));
    chk("mr.full",  {31'd0, alu_ready}, 32'd0);
    chk("mr.wen",   {31'd0, RegWEn}, 32'd1);
    drive(1'b0, 5'd0, F3_LW, 2'd0, 32'h0, 1'b1, 5'd20, 32'h20);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("mr%0d.wen", c),  {31'd0, RegWEn},    32'd0);
      chk($sformatf("mr%0d.pend", c), pend_mask,          32'd0);
      chk($sformatf("mr%0d.busy", c), {31'd0, busy},      32'd0);
      chk($sformatf("mr%0d.ardy", c), {31'd0, alu_ready}, 32'd0);
      chk($sformatf("mr%0d.lrdy", c), {31'd0, ld_ready},  32'd0);
    end
    reset = 1'b1;
    drive(1'b0, 5'd0, F3_LW, 2'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    chk("mr.post.wen",  {31'd0, RegWEn},    32'd0);
    chk("mr.post.busy", {31'd0, busy},      32'd0);
    chk("mr.post.ardy", {31'd0, alu_ready}, 32'd1);
    chk("mr.post.lrdy", {31'd0, ld_ready},  32'd1);
    chk("mr.post.pend", pend_mask,          32'd0);
    drive(1'b0, 5'd0, F3_LW, 2'd0, 32'h0, 1'b1, 5'd0, 32'h55);
    step();
    chk("rd0.wen",  {31'd0, RegWEn}, 32'd0);
    chk("rd0.busy", {31'd0, busy},   32'd0);
    drive(1'b0, 5'd0, F3_LW, 2'd0, 32'h0, 1'b1, 5'd5, 32'h66);
    step();
    chk("post.wen",  {31'd0, RegWEn}, 32'd1);
    chk("post.data", wb_data,         32'h66);
    drive(1'b0, 5'd0, F3_LW, 2'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Writeback-side producer for the CPU register file. It drives the file's single write port (RegWEn/regD/wb_data).
- It merges two result sources: single-cycle ALU results and late-returning load data from the LSU.
- Loads are sign/zero-extended here. ALU results that lose arbitration are buffered in a small in-order FIFO.
- It exports a pending-destination mask so the hazard unit can stall readers of registers not yet written.

Parameters:
- DEPTH, 2, ALU result FIFO entries (power of two, ≥2).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- alu_valid  in  1  ALU result present.
- alu_rd  in  5  ALU destination.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready.
- ld_valid  in  1  load data returning this cycle.
- ld_rd  in  5  load destination.
- ld_funct3  in  3  load type (RV32I encoding).
- ld_addr_lo  in  2  byte offset of the load address.
- ld_rdata  in  XLEN  raw aligned memory word.
- ld_ready  out  1  load accepted.
- RegWEn  out  1  register file write enable.
- regD  out  5  register file write address.
- wb_data  out  XLEN  register file write data.
- pend_mask  out  32  bit r set while a valid FIFO entry targets xr.
- busy  out  1  FIFO non-empty or output stage holds a write.

Behaviour:
- Reset (reset==0 at posedge):
  - RegWEn=0, regD=0, wb_data=0.
  - FIFO emptied (all entries invalid), pend_mask=0, busy=0.
  - While reset is low, alu_ready=0 and ld_ready=0, and inputs are ignored.
  - Reset mid-operation discards all buffered results; no write is issued.
- Handshakes:
  - ld_ready=1 whenever out of reset. Loads always win and are never stalled.
  - alu_ready = !full, from the registered count only. There is no combinational path from any input.
- Output stage: registered. A result selected in cycle t appears on RegWEn/regD/wb_data in cycle t+1 for exactly one cycle. RegWEn is 0 in any cycle with no selection.
- Per-cycle selection priority:
  1. Load, if ld_valid.
  2. Else the FIFO head, if the FIFO is non-empty.
  3. Else the incoming ALU result (bypass), only if the FIFO is empty.
- A handshaken ALU result that is not selected is pushed at the FIFO tail.
- Order is preserved: the bypass is used only when the FIFO is empty.
- With the FIFO full and no load: the head pops. No push occurs that cycle (alu_ready was 0). alu_ready rises the following cycle.
- rd==0 results:
  - They are handshaken normally but never pushed and never written (RegWEn stays 0).
  - pend_mask[0] is always 0.
- Squash rule (contract: a returning load is younger than every FIFO entry):
  - When a load is selected, every valid FIFO entry with rd==ld_rd is invalidated that cycle.
  - An invalid entry reaching the head is popped in one cycle with no write issued.
  - An ALU result pushed in the same cycle is not squashed.
- pend_mask: OR of one-hot(rd) over valid FIFO entries, registered, updated on each push, pop and squash. The output-stage entry is not included; the hazard unit covers that cycle via forwarding.
- Load extension (combinational, before the output register):
  - LB (000) / LBU (100): byte ld_addr_lo, sign- or zero-extended.
  - LH (001) / LHU (101): halfword ld_addr_lo[1], sign- or zero-extended.
  - LW (010) and all other codes: the raw word.
  - Misaligned halfwords use ld_addr_lo[1] only; ld_addr_lo[0] is ignored.
- Width rules: all results are XLEN bits; no arithmetic beyond extension. The FIFO count is $clog2(DEPTH)+1 bits, and its pointers wrap modulo DEPTH.

Decomposition:
- Shared package holds:
  - load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU;
  - XLEN;
  - the register-index width (5).
- One natural combinational sub-module: load_ext (funct3, addr_lo, rdata → extended data), reusable by the LSU.
- FIFO storage and control stay inline.

Test Plan:
- Reset release, then alu_valid with rd=5, data=0x11 → next cycle RegWEn=1, regD=5, wb_data=0x11; pend_mask stays 0.
- Simultaneous ld_valid (rd=7, LW, 0xDEADBEEF) and alu_valid (rd=3, 0x22):
  - cycle+1 writes x7=0xDEADBEEF;
  - cycle+2 writes x3=0x22;
  - pend_mask[3]=1 only during the buffered cycle.
- Back-to-back loads for 4 cycles with ALU valid every cycle → 2 ALU pushes then alu_ready=0; after the loads end, FIFO drains in order with no drops.
- ALU rd=9 (0x1) buffered, then load rd=9 selected → x9 written once with the load value; the squashed entry pops with RegWEn=0 and pend_mask[9] clears.
- Load extension with ld_rdata=0x80F0_7F81:
  - LB off3 → 0xFFFFFF80;
  - LBU off0 → 0x00000081;
  - LH off2 → 0xFFFF80F0;
  - LHU off0 → 0x00007F81.
- Reset asserted with 2 FIFO entries pending → no further writes, pend_mask=0, busy=0, alu_ready=0 until release; rd=0 ALU result afterwards gives RegWEn=0.
